// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 timing constants, derived totals/widths and scan FSM encoding.
package vga_timing_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned H_FP     = 16;
   localparam int unsigned H_SYNC   = 96;
   localparam int unsigned H_BP     = 48;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_FP     = 10;
   localparam int unsigned V_SYNC   = 2;
   localparam int unsigned V_BP     = 33;
   localparam logic        SYNC_POL = 1'b0;

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int unsigned RGB_W = 12;

   // Bits needed to hold 0..n-1 (at least one).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned HCNT_W = cnt_width(H_TOTAL);
   localparam int unsigned VCNT_W = cnt_width(V_TOTAL);
   localparam int unsigned ADDR_W = cnt_width(H_ACTIVE * V_ACTIVE);

   typedef enum logic [0:0] {StIdle, StScan} scan_state_e;

endpackage

// File: rtl/vga_timing_cnt.sv
// Horizontal/vertical raster counters with wrap, run/hold control and end-of-frame flag.
module vga_timing_cnt
   import vga_timing_pkg::*;
#(
   parameter int unsigned HTotal = H_TOTAL,
   parameter int unsigned VTotal = V_TOTAL,
   parameter int unsigned HW     = cnt_width(HTotal),
   parameter int unsigned VW     = cnt_width(VTotal)
) (
   input  logic          clk_i,
   input  logic          rst_n,
   input  logic          run_i,
   output logic [HW-1:0] hcnt_o,
   output logic [VW-1:0] vcnt_o,
   output logic          eof_o
);

   localparam logic [HW-1:0] HLast = HW'(HTotal - 1);
   localparam logic [VW-1:0] VLast = VW'(VTotal - 1);

   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [VW-1:0] vcnt_q, vcnt_d;
   logic          hwrap, vwrap;

   // Advance the raster position while running; hold otherwise.
   always_comb begin
      hwrap  = (hcnt_q == HLast);
      vwrap  = (vcnt_q == VLast);
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (run_i) begin
         if (hwrap) begin
            hcnt_d = '0;
            vcnt_d = vwrap ? '0 : vcnt_q + 1'b1;
         end else begin
            hcnt_d = hcnt_q + 1'b1;
         end
      end
   end

   // Counter state registers.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_q <= '0;
         vcnt_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   assign hcnt_o = hcnt_q;
   assign vcnt_o = vcnt_q;
   assign eof_o  = hwrap && vwrap;

endmodule

// File: rtl/vga_scan_rd.sv
// Frame-buffer scan-out reader: raster timing, linear read address, 2-stage output pipeline.
module vga_scan_rd
   import vga_timing_pkg::*;
#(
   parameter int unsigned HActive = H_ACTIVE,
   parameter int unsigned HFp     = H_FP,
   parameter int unsigned HSync   = H_SYNC,
   parameter int unsigned HBp     = H_BP,
   parameter int unsigned VActive = V_ACTIVE,
   parameter int unsigned VFp     = V_FP,
   parameter int unsigned VSync   = V_SYNC,
   parameter int unsigned VBp     = V_BP,
   parameter logic        SyncPol = SYNC_POL
) (
   input  logic             rclk_i,
   input  logic             rst_n,
   input  logic             en_i,
   output logic [31:0]      raddr_o,
   input  logic [RGB_W-1:0] rdata_i,
   output logic [3:0]       vga_r_o,
   output logic [3:0]       vga_g_o,
   output logic [3:0]       vga_b_o,
   output logic             vga_hs_o,
   output logic             vga_vs_o,
   output logic             vga_de_o,
   output logic             frame_start_o
);

   localparam int unsigned HTotal = HActive + HFp + HSync + HBp;
   localparam int unsigned VTotal = VActive + VFp + VSync + VBp;
   localparam int unsigned HW     = cnt_width(HTotal);
   localparam int unsigned VW     = cnt_width(VTotal);
   localparam int unsigned AddrW  = cnt_width(HActive * VActive);

   localparam logic [HW-1:0] HActLast   = HW'(HActive - 1);
   localparam logic [HW-1:0] HSyncFirst = HW'(HActive + HFp);
   localparam logic [HW-1:0] HSyncLast  = HW'(HActive + HFp + HSync - 1);
   localparam logic [VW-1:0] VActLast   = VW'(VActive - 1);
   localparam logic [VW-1:0] VSyncFirst = VW'(VActive + VFp);
   localparam logic [VW-1:0] VSyncLast  = VW'(VActive + VFp + VSync - 1);

   scan_state_e state_q, state_d;
   logic        scan;

   logic [HW-1:0]    hcnt;
   logic [VW-1:0]    vcnt;
   logic             eof;
   logic [AddrW-1:0] addr_q, addr_d;

   // Stage 0 flags
   logic act0, hs0, vs0, first0, last0;
   // Stage 1 flags (aligned with rdata)
   logic act1_q, hs1_q, vs1_q, first1_q;
   // Stage 2 pin registers
   logic [RGB_W-1:0] rgb_q;
   logic             de_q, hs_q, vs_q, fs_q;

   vga_timing_cnt #(
      .HTotal (HTotal),
      .VTotal (VTotal),
      .HW     (HW),
      .VW     (VW)
   ) u_cnt (
      .clk_i  (rclk_i),
      .rst_n  (rst_n),
      .run_i  (scan),
      .hcnt_o (hcnt),
      .vcnt_o (vcnt),
      .eof_o  (eof)
   );

   // Scan FSM next state: en is honoured only at a frame boundary.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (en_i) state_d = StScan;
         StScan: if (eof && !en_i) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Stage-0 raster flags and next read address.
   always_comb begin
      scan   = (state_q == StScan);
      act0   = scan && (hcnt <= HActLast) && (vcnt <= VActLast);
      hs0    = scan && (hcnt >= HSyncFirst) && (hcnt <= HSyncLast);
      vs0    = scan && (vcnt >= VSyncFirst) && (vcnt <= VSyncLast);
      first0 = scan && (hcnt == '0) && (vcnt == '0);
      last0  = act0 && (hcnt == HActLast) && (vcnt == VActLast);
      addr_d = addr_q;
      if (!scan || last0) begin
         addr_d = '0;
      end else if (act0) begin
         addr_d = addr_q + 1'b1;
      end
   end

   // FSM state and address counter.
   always_ff @(posedge rclk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   // Two-stage pipeline: delay flags past the RAM latency, then register pins.
   always_ff @(posedge rclk_i or negedge rst_n) begin
      if (!rst_n) begin
         act1_q   <= 1'b0;
         hs1_q    <= 1'b0;
         vs1_q    <= 1'b0;
         first1_q <= 1'b0;
         rgb_q    <= '0;
         de_q     <= 1'b0;
         hs_q     <= ~SyncPol;
         vs_q     <= ~SyncPol;
         fs_q     <= 1'b0;
      end else begin
         act1_q   <= act0;
         hs1_q    <= hs0;
         vs1_q    <= vs0;
         first1_q <= first0;
         rgb_q    <= act1_q ? rdata_i : '0;
         de_q     <= act1_q;
         hs_q     <= hs1_q ? SyncPol : ~SyncPol;
         vs_q     <= vs1_q ? SyncPol : ~SyncPol;
         fs_q     <= first1_q;
      end
   end

   assign raddr_o       = 32'(addr_q);
   assign vga_r_o       = rgb_q[11:8];
   assign vga_g_o       = rgb_q[7:4];
   assign vga_b_o       = rgb_q[3:0];
   assign vga_de_o      = de_q;
   assign vga_hs_o      = hs_q;
   assign vga_vs_o      = vs_q;
   assign frame_start_o = fs_q;

endmodule

// File: tb/tb_vga_scan_rd.sv
// Bench for vga_scan_rd on a reduced raster, checked against a frame-position model.
module tb_vga_scan_rd;

   localparam int HA  = 32;
   localparam int HFP = 4;
   localparam int HS  = 6;
   localparam int HBP = 6;
   localparam int VA  = 24;
   localparam int VFP = 2;
   localparam int VS  = 2;
   localparam int VBP = 3;
   localparam int HT  = HA + HFP + HS + HBP;   // 48
   localparam int VT  = VA + VFP + VS + VBP;   // 31
   localparam int FT  = HT * VT;               // 1488
   localparam int NPIX = HA * VA;              // 768

   typedef struct packed {
      logic [11:0] rgb;
      logic        de;
      logic        hs;
      logic        vs;
      logic        fs;
   } pin_t;

   localparam pin_t IdlePins = {12'h000, 1'b0, 1'b1, 1'b1, 1'b0};

   logic        rclk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [31:0] raddr;
   logic [11:0] rdata;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, vga_de, frame_start;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   logic [11:0] mem [1024];

   vga_scan_rd #(
      .HActive (HA),
      .HFp     (HFP),
      .HSync   (HS),
      .HBp     (HBP),
      .VActive (VA),
      .VFp     (VFP),
      .VSync   (VS),
      .VBp     (VBP),
      .SyncPol (1'b0)
   ) dut (
      .rclk_i        (rclk),
      .rst_n         (rst_n),
      .en_i          (en),
      .raddr_o       (raddr),
      .rdata_i       (rdata),
      .vga_r_o       (vga_r),
      .vga_g_o       (vga_g),
      .vga_b_o       (vga_b),
      .vga_hs_o      (vga_hs),
      .vga_vs_o      (vga_vs),
      .vga_de_o      (vga_de),
      .frame_start_o (frame_start)
   );

   always #5 rclk = ~rclk;

   // RAM with one-cycle read latency.
   always @(posedge rclk) rdata <= mem[raddr[9:0]];

   // Expected pins for a frame position k while scanning.
   function automatic pin_t stage0(input bit scan, input int k);
      pin_t p;
      int h, v;
      p = IdlePins;
      if (scan) begin
         h = k % HT;
         v = k / HT;
         p.de  = (h < HA) && (v < VA);
         p.rgb = p.de ? mem[v * HA + h] : 12'h000;
         p.hs  = !((h >= HA + HFP) && (h < HA + HFP + HS));
         p.vs  = !((v >= VA + VFP) && (v < VA + VFP + VS));
         p.fs  = (k == 0);
      end
      return p;
   endfunction

   // Expected read address: number of visible pixels already passed this frame.
   function automatic int exp_addr(input bit scan, input int k);
      int h, v, n;
      if (!scan) return 0;
      h = k % HT;
      v = k / HT;
      n = (v < VA) ? v * HA + ((h < HA) ? h : HA) : NPIX;
      return (n == NPIX) ? 0 : n;
   endfunction

   bit   m_scan;
   int   m_k;
   pin_t pipe0, pipe1;
   pin_t act_pins;

   // Model: frame position plus a two-cycle pin delay.
   always @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
         m_scan <= 1'b0;
         m_k    <= 0;
         pipe0  <= IdlePins;
         pipe1  <= IdlePins;
      end else begin
         pipe0 <= stage0(m_scan, m_k);
         pipe1 <= pipe0;
         if (!m_scan || m_k == FT - 1) begin
            m_scan <= en;
            m_k    <= 0;
         end else begin
            m_k <= m_k + 1;
         end
      end
   end

   // Per-cycle compare of pins and address against the model.
   always @(negedge rclk) begin
      if (chk_on) begin
         act_pins = {vga_r, vga_g, vga_b, vga_de, vga_hs, vga_vs, frame_start};
         checks++;
         if (act_pins !== pipe1) begin
            errors++;
            $display("FAIL pins t=%0t: got rgb=%h de=%b hs=%b vs=%b fs=%b want rgb=%h de=%b hs=%b vs=%b fs=%b",
                     $time, act_pins.rgb, act_pins.de, act_pins.hs, act_pins.vs, act_pins.fs,
                     pipe1.rgb, pipe1.de, pipe1.hs, pipe1.vs, pipe1.fs);
         end
         checks++;
         if (raddr !== 32'(exp_addr(m_scan, m_k))) begin
            errors++;
            $display("FAIL raddr t=%0t: got %0d want %0d", $time, raddr, exp_addr(m_scan, m_k));
         end
      end
   end

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic check_idle_pins(input string name);
      check({name, " rgb"}, int'({vga_r, vga_g, vga_b}), 0);
      check({name, " de"}, int'(vga_de), 0);
      check({name, " hs"}, int'(vga_hs), 1);
      check({name, " vs"}, int'(vga_vs), 1);
      check({name, " fs"}, int'(frame_start), 0);
      check({name, " raddr"}, int'(raddr), 0);
   endtask

   // Wait for frame_start at the pins; returns negedges taken (-1 if bound hit).
   task automatic wait_fs(input int bound, output int n);
      n = -1;
      for (int i = 1; i <= bound; i++) begin
         @(negedge rclk);
         #1;
         if (frame_start) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wait_model_idle(input string name);
      int i;
      i = 0;
      while (m_scan && i < 2 * FT) begin
         @(negedge rclk);
         i++;
      end
      check({name, " reached idle"}, int'(m_scan), 0);
   endtask

   initial begin
      int n, de_cnt, hs_low, vs_low, max_addr, t;
      bit got_it;

      rst_n = 1'b0;
      en    = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 12'(i);
      repeat (3) @(negedge rclk);
      rst_n  = 1'b1;
      chk_on = 1'b1;

      // Idle with en low.
      repeat (100) @(negedge rclk);
      #1;
      check_idle_pins("idle");

      // Start scanning; first pixel reaches pins 3 negedges after en is driven.
      @(negedge rclk);
      en = 1'b1;
      wait_fs(10, n);
      check("first fs latency", n, 3);
      check("pixel0 rgb", int'({vga_r, vga_g, vga_b}), 0);
      check("pixel0 de", int'(vga_de), 1);

      // One full frame from frame_start to frame_start.
      de_cnt   = int'(vga_de);
      hs_low   = int'(!vga_hs);
      vs_low   = int'(!vga_vs);
      max_addr = int'(raddr);
      n = 0;
      got_it = 1'b0;
      for (int i = 0; i < 2 * FT; i++) begin
         @(negedge rclk);
         #1;
         n++;
         if (frame_start) begin
            got_it = 1'b1;
            break;
         end
         if (n == 1) check("pixel1 rgb", int'({vga_r, vga_g, vga_b}), 1);
         if (n == 2 * HT + 5) check("pixel(5,2) rgb", int'({vga_r, vga_g, vga_b}), 69);
         de_cnt += int'(vga_de);
         hs_low += int'(!vga_hs);
         vs_low += int'(!vga_vs);
         if (int'(raddr) > max_addr) max_addr = int'(raddr);
      end
      check("frame fs seen", int'(got_it), 1);
      check("frame period", n, 1488);
      check("de per frame", de_cnt, 768);
      check("hs low per frame", hs_low, 6 * 31);
      check("vs low per frame", vs_low, 2 * 48);
      check("max raddr", max_addr, 767);

      // Drop en mid-frame: the frame must finish, then go idle.
      repeat (10 * HT) @(negedge rclk);
      en = 1'b0;
      repeat (HT) @(negedge rclk);
      #1;
      check("still scanning after en drop", int'(m_scan), 1);
      wait_model_idle("en drop");
      repeat (20) @(negedge rclk);
      #1;
      check_idle_pins("after drop");

      // Re-enable.
      @(negedge rclk);
      en = 1'b1;
      wait_fs(10, n);
      check("restart fs latency", n, 3);
      check("restart pixel0 de", int'(vga_de), 1);

      // Asynchronous reset at (h=20, v=12).
      got_it = 1'b0;
      for (int i = 0; i < 2 * FT; i++) begin
         @(posedge rclk);
         #2;
         if (m_scan && m_k == 12 * HT + 20) begin
            got_it = 1'b1;
            break;
         end
      end
      check("reached reset point", int'(got_it), 1);
      rst_n = 1'b0;
      #1;
      check_idle_pins("async reset");
      @(negedge rclk);
      rst_n = 1'b1;
      wait_fs(10, n);
      check("post-reset fs latency", n, 3);
      check("post-reset raddr", int'(raddr), 2);

      // Randomised frame data and en toggling.
      en = 1'b0;
      wait_model_idle("pre-random");
      repeat (5) @(negedge rclk);
      for (int i = 0; i < 1024; i++) mem[i] = 12'($urandom);
      for (int it = 0; it < 10; it++) begin
         @(negedge rclk);
         en = ($urandom_range(0, 3) != 0);
         t  = int'($urandom_range(30, 1600));
         repeat (t) @(negedge rclk);
      end
      en = 1'b0;
      wait_model_idle("final");
      repeat (5) @(negedge rclk);
      #1;
      check_idle_pins("final idle");

      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
